// File: rtl/upsample_line_sched.sv
// upsample_line_sched: line-slot scheduler with NUM/DEN vertical stepping for the 8-slot upsample line buffer
module upsample_line_sched #(
  parameter int SLOT_AW     = 11,
  parameter int V_NUM       = 2,
  parameter int V_DEN       = 5,
  parameter int PRIME_LINES = 2
) (
  input  logic               clk_out,
  input  logic               reset_n,
  input  logic               i_frame_start,
  input  logic               i_wr_line_done,
  input  logic               i_rd_line_start,
  output logic [2:0]         o_wr_slot,
  output logic [2:0]         o_rd_slot,
  output logic [SLOT_AW+2:0] o_wr_base,
  output logic [SLOT_AW+2:0] o_rd_base,
  output logic               o_rd_valid,
  output logic [3:0]         o_fill,
  output logic               o_overrun,
  output logic               o_underrun
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t     r_state, w_state_nx;
  logic [2:0] r_wr_slot, r_rd_slot, w_wr_slot_nx, w_rd_slot_nx;
  logic [3:0] r_fill, w_fill_nx;
  logic [7:0] r_acc, w_acc_nx;
  logic       r_ovr, r_unr, w_ovr_nx, w_unr_nx;
  logic [8:0] w_sum;
  logic       w_wr, w_rd, w_step, w_rd_adv, w_ovr;
  // Next-state: frame restart wins; an overrun drops the oldest line so rd moves once and fill pins at 8
  always_comb begin
    w_sum        = {1'b0, r_acc} + 9'(V_NUM);
    w_wr         = i_wr_line_done && r_state != IDLE;
    w_rd         = i_rd_line_start && r_state == RUN;
    w_step       = w_rd && w_sum >= 9'(V_DEN);
    w_rd_adv     = w_step && r_fill >= 4'd2;
    w_ovr        = w_wr && r_fill == 4'd8;
    w_state_nx   = i_frame_start ? PRIME :
                   (r_state == PRIME && r_fill >= 4'(PRIME_LINES)) ? RUN : r_state;
    w_wr_slot_nx = i_frame_start ? 3'd0 : r_wr_slot + 3'(w_wr);
    w_rd_slot_nx = i_frame_start ? 3'd0 : r_rd_slot + 3'(w_ovr || w_rd_adv);
    w_fill_nx    = i_frame_start ? 4'd0 : w_ovr ? 4'd8 : r_fill + 4'(w_wr) - 4'(w_rd_adv);
    w_acc_nx     = i_frame_start ? 8'd0 : !w_rd ? r_acc :
                   w_step ? 8'(w_sum - 9'(V_DEN)) : w_sum[7:0];
    w_ovr_nx     = !i_frame_start && w_ovr;
    w_unr_nx     = !i_frame_start && w_step && !w_rd_adv;
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk_out) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_wr_slot <= '0;
      r_rd_slot <= '0;
      r_fill    <= '0;
      r_acc     <= '0;
      r_ovr     <= 1'b0;
      r_unr     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_wr_slot <= w_wr_slot_nx;
      r_rd_slot <= w_rd_slot_nx;
      r_fill    <= w_fill_nx;
      r_acc     <= w_acc_nx;
      r_ovr     <= w_ovr_nx;
      r_unr     <= w_unr_nx;
    end
  end
  assign o_wr_slot  = r_wr_slot;
  assign o_rd_slot  = r_rd_slot;
  assign o_wr_base  = {r_wr_slot, {SLOT_AW{1'b0}}};
  assign o_rd_base  = {r_rd_slot, {SLOT_AW{1'b0}}};
  assign o_rd_valid = r_state == RUN;
  assign o_fill     = r_fill;
  assign o_overrun  = r_ovr;
  assign o_underrun = r_unr;
endmodule

// File: tb/tb_upsample_line_sched.sv
// tb_upsample_line_sched: directed vectors with a scoreboard queue checked by a per-cycle monitor
module tb_upsample_line_sched;
  logic        clk_out = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_wr_line_done = 1'b0;
  logic        i_rd_line_start = 1'b0;
  logic [2:0]  o_wr_slot, o_rd_slot;
  logic [13:0] o_wr_base, o_rd_base;
  logic        o_rd_valid;
  logic [3:0]  o_fill;
  logic        o_overrun, o_underrun;
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  upsample_line_sched dut (
    .clk_out(clk_out), .reset_n(reset_n), .i_frame_start(i_frame_start),
    .i_wr_line_done(i_wr_line_done), .i_rd_line_start(i_rd_line_start),
    .o_wr_slot(o_wr_slot), .o_rd_slot(o_rd_slot), .o_wr_base(o_wr_base), .o_rd_base(o_rd_base),
    .o_rd_valid(o_rd_valid), .o_fill(o_fill), .o_overrun(o_overrun), .o_underrun(o_underrun)
  );
  always #5 clk_out = ~clk_out;
  // expected packing: {wr_slot, rd_slot, rd_valid, fill, overrun, underrun}
  task automatic step(input logic rn, fs, wr, rd, input logic [2:0] ew, er,
                      input logic ev, input logic [3:0] ef, input logic eo, eu);
    @(negedge clk_out);
    reset_n = rn;
    i_frame_start = fs;
    i_wr_line_done = wr;
    i_rd_line_start = rd;
    exp_q.push_back({ew, er, ev, ef, eo, eu});
  endtask
  always @(posedge clk_out) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      logic [12:0] e, a;
      e = exp_q.pop_front();
      a = {o_wr_slot, o_rd_slot, o_rd_valid, o_fill, o_overrun, o_underrun};
      checks++;
      if (a !== e || o_wr_base !== {e[12:10], 11'b0} || o_rd_base !== {e[9:7], 11'b0}) begin
        errors++;
        $display("FAIL cycle%0d wr/rd/v/fill/ov/un got %0d/%0d/%0d/%0d/%0d/%0d bases %h/%h want %0d/%0d/%0d/%0d/%0d/%0d",
                 cyc, a[12:10], a[9:7], a[6], a[5:2], a[1], a[0], o_wr_base, o_rd_base,
                 e[12:10], e[9:7], e[6], e[5:2], e[1], e[0]);
      end
    end
  end
  initial begin
    // reset, then pulses ignored in IDLE
    step(0,0,0,0, 0,0,0,0,0,0);
    step(0,0,0,0, 0,0,0,0,0,0);
    step(1,0,1,0, 0,0,0,0,0,0);
    step(1,0,0,1, 0,0,0,0,0,0);
    // frame start and prime with two lines
    step(1,1,0,0, 0,0,0,0,0,0);
    step(1,0,1,0, 1,0,0,1,0,0);
    step(1,0,1,1, 2,0,0,2,0,0);
    step(1,0,0,0, 2,0,1,2,0,0);
    // fill to 5, then 5 reads: acc 2,4,1,3,0
    step(1,0,1,0, 3,0,1,3,0,0);
    step(1,0,1,0, 4,0,1,4,0,0);
    step(1,0,1,0, 5,0,1,5,0,0);
    step(1,0,0,1, 5,0,1,5,0,0);
    step(1,0,0,1, 5,0,1,5,0,0);
    step(1,0,0,1, 5,1,1,4,0,0);
    step(1,0,0,1, 5,1,1,4,0,0);
    step(1,0,0,1, 5,2,1,3,0,0);
    // simultaneous write + advancing read at fill 3: acc 2,4,1
    step(1,0,0,1, 5,2,1,3,0,0);
    step(1,0,0,1, 5,2,1,3,0,0);
    step(1,0,1,1, 6,3,1,3,0,0);
    // drain to fill 1: acc 3,0,2,4,1
    step(1,0,0,1, 6,3,1,3,0,0);
    step(1,0,0,1, 6,4,1,2,0,0);
    step(1,0,0,1, 6,4,1,2,0,0);
    step(1,0,0,1, 6,4,1,2,0,0);
    step(1,0,0,1, 6,5,1,1,0,0);
    // underruns at fill 1: acc 3, then 5 -> underrun (acc 0), 2, 4, 6 -> underrun (acc 1)
    step(1,0,0,1, 6,5,1,1,0,0);
    step(1,0,0,1, 6,5,1,1,0,1);
    step(1,0,0,0, 6,5,1,1,0,0);
    step(1,0,0,1, 6,5,1,1,0,0);
    step(1,0,0,1, 6,5,1,1,0,0);
    step(1,0,0,1, 6,5,1,1,0,1);
    step(1,0,0,0, 6,5,1,1,0,0);
    step(1,0,0,1, 6,5,1,1,0,0);
    step(1,0,0,1, 6,5,1,1,0,1);
    // restart frame, prime, then 9 writes with no reads
    step(1,1,0,0, 0,0,0,0,0,0);
    step(1,0,1,0, 1,0,0,1,0,0);
    step(1,0,1,0, 2,0,0,2,0,0);
    step(1,0,0,0, 2,0,1,2,0,0);
    step(1,0,1,0, 3,0,1,3,0,0);
    step(1,0,1,0, 4,0,1,4,0,0);
    step(1,0,1,0, 5,0,1,5,0,0);
    step(1,0,1,0, 6,0,1,6,0,0);
    step(1,0,1,0, 7,0,1,7,0,0);
    step(1,0,1,0, 0,0,1,8,0,0);
    step(1,0,1,0, 1,1,1,8,1,0);
    step(1,0,1,0, 2,2,1,8,1,0);
    step(1,0,1,0, 3,3,1,8,1,0);
    step(1,0,0,0, 3,3,1,8,0,0);
    // overrun together with read advance: rd moves once, fill stays 8
    step(1,0,0,1, 3,3,1,8,0,0);
    step(1,0,0,1, 3,3,1,8,0,0);
    step(1,0,1,1, 4,4,1,8,1,0);
    step(1,0,0,1, 4,4,1,8,0,0);
    step(1,0,0,1, 4,5,1,7,0,0);
    // frame start coincident with wr and rd in RUN
    step(1,1,1,1, 0,0,0,0,0,0);
    step(1,0,0,0, 0,0,0,0,0,0);
    step(1,0,0,1, 0,0,0,0,0,0);
    step(1,0,1,0, 1,0,0,1,0,0);
    // reach RUN with fill 5, then reset held 3 cycles
    step(1,0,1,0, 2,0,0,2,0,0);
    step(1,0,0,0, 2,0,1,2,0,0);
    step(1,0,1,0, 3,0,1,3,0,0);
    step(1,0,1,0, 4,0,1,4,0,0);
    step(1,0,1,0, 5,0,1,5,0,0);
    step(0,0,0,0, 0,0,0,0,0,0);
    step(0,0,1,1, 0,0,0,0,0,0);
    step(0,0,0,0, 0,0,0,0,0,0);
    step(1,0,1,0, 0,0,0,0,0,0);
    step(1,0,0,1, 0,0,0,0,0,0);
    step(1,1,0,0, 0,0,0,0,0,0);
    step(1,0,1,0, 1,0,0,1,0,0);
    @(negedge clk_out);
    i_wr_line_done = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_out);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
